// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 scan-code decoder.
package ps2_pkg;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_event_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } dec_state_t;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_F0 = 8'hF0;

  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_ACK   = 8'hFA;
  localparam logic [7:0] PS2_BATF  = 8'hFC;
  localparam logic [7:0] PS2_RSND  = 8'hFE;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Keyboard protocol bytes that never represent a key.
  function automatic logic is_drop(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_BAT) || (b == PS2_ECHO) || (b == PS2_ACK) ||
           (b == PS2_BATF) || (b == PS2_RSND) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO; pointers carry one extra wrap bit to tell full from empty.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  ps2_event_t push_data,
  input  logic       pop,
  output ps2_event_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A same-cycle pop makes room, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 prefix bytes into key events and queues them for the CPU side.
// Optional typematic-repeat filter: define PS2DEC_TYPEMATIC_FILTER_EN.
//
// state      | meaning
// ST_IDLE    | waiting for a key byte or prefix
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 F0 seen
// ST_PAUSE   | swallowing the rest of the E1 pause sequence
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = (TW > 20) ? TW : 20;

  dec_state_t  state;
  logic [2:0]  skip_cnt;
  logic [CW-1:0] idle_cnt;
  logic        emit;
  logic        push_req;
  ps2_event_t  ev_new;
  ps2_event_t  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  always_comb begin
    emit   = 1'b0;
    ev_new = '0;
    if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (byte_data != PS2_E0 && byte_data != PS2_F0 &&
              byte_data != PS2_E1 && !is_drop(byte_data)) begin
            emit   = 1'b1;
            ev_new = '{code: byte_data, ext: 1'b0, brk: 1'b0};
          end
        end
        ST_EXT: begin
          if (byte_data != PS2_F0 && byte_data != PS2_E0) begin
            emit   = 1'b1;
            ev_new = '{code: byte_data, ext: 1'b1, brk: 1'b0};
          end
        end
        ST_BRK: begin
          emit   = 1'b1;
          ev_new = '{code: byte_data, ext: 1'b0, brk: 1'b1};
        end
        ST_EXT_BRK: begin
          emit   = 1'b1;
          ev_new = '{code: byte_data, ext: 1'b1, brk: 1'b1};
        end
        ST_PAUSE: begin
          if (skip_cnt == 3'd1) begin
            emit   = 1'b1;
            ev_new = '{code: PS2_E1, ext: 1'b0, brk: 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      if (byte_valid)                        idle_cnt <= '0;
      else if (idle_cnt < CW'(TIMEOUT_CYC))  idle_cnt <= idle_cnt + 1'b1;

      if (byte_valid) begin
        case (state)
          ST_IDLE: begin
            if (byte_data == PS2_E0)      state <= ST_EXT;
            else if (byte_data == PS2_F0) state <= ST_BRK;
            else if (byte_data == PS2_E1) begin
              state    <= ST_PAUSE;
              skip_cnt <= PAUSE_SKIP;
            end
          end
          ST_EXT: begin
            if (byte_data == PS2_F0)      state <= ST_EXT_BRK;
            else if (byte_data != PS2_E0) state <= ST_IDLE;
          end
          ST_BRK, ST_EXT_BRK: state <= ST_IDLE;
          ST_PAUSE: begin
            skip_cnt <= skip_cnt - 1'b1;
            if (skip_cnt == 3'd1) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && idle_cnt >= CW'(TIMEOUT_CYC - 1)) begin
        state <= ST_IDLE;
      end
    end
  end

`ifdef PS2DEC_TYPEMATIC_FILTER_EN
  logic [511:0] held;
  logic [8:0]   key;

  assign key      = {ev_new.ext, ev_new.code};
  assign push_req = emit && !(!ev_new.brk && held[key]);

  // Map tracks every emitted event, even ones the FIFO ends up dropping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     held      <= '0;
    else if (emit) held[key] <= !ev_new.brk;
  end
`else
  assign push_req = emit;
`endif

  assign pop = ev_valid && ev_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               overflow <= 1'b0;
    else if (push_req && fifo_full && !pop)  overflow <= 1'b1;
    else if (ovf_clr)                        overflow <= 1'b0;
  end

  ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (ev_new),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: directed byte streams, queued expected events.
module tb_ps2_scancode_decoder;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       overflow;
  logic       ovf_clr;

  int vectors = 0;
  int errors  = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.DEPTH(8), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back({code, ext, brk});
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was sampled.
  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: %0d events still expected, got none", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    chk("no_extra_event", {9'd0, ev_valid}, 10'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head is compared against the oldest expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_event: got %h, expected none", {ev_code, ev_ext, ev_break});
        end else begin
          chk("scoreboard", {ev_code, ev_ext, ev_break}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; ev_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ev_valid", {9'd0, ev_valid}, 10'd0);
    chk("rst_head", {ev_code, ev_ext, ev_break}, 10'd0);
    chk("rst_overflow", {9'd0, overflow}, 10'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // make / break with one-cycle latency
    expect_ev(8'h1C, 0, 0);
    send(8'h1C);
    @(negedge clk);
    chk("latency_make", {9'd0, ev_valid}, 10'd1);
    @(posedge clk);
    #1;
    send(8'hF0);
    @(negedge clk);
    chk("prefix_no_event", {9'd0, ev_valid}, 10'd0);
    @(posedge clk);
    #1;
    expect_ev(8'h1C, 0, 1);
    send(8'h1C);
    @(negedge clk);
    chk("latency_break", {9'd0, ev_valid}, 10'd1);
    @(posedge clk);
    #1;
    drain();

    // extended keys, protocol bytes interleaved, repeated E0
    expect_ev(8'h75, 1, 0);
    expect_ev(8'h75, 1, 1);
    expect_ev(8'h75, 1, 0);
    send(8'hAA); send(8'hE0); send(8'h75); send(8'hFA);
    send(8'hE0); send(8'hF0); send(8'h75); send(8'hFE);
    send(8'hE0); send(8'hE0); send(8'h75);
    drain();

    // pause sequence collapses to one event
    expect_ev(8'hE1, 0, 0);
    expect_ev(8'h1C, 0, 0);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    drain();

    // overflow, clear, set-wins, and push while full with pop
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
    for (int i = 0; i < 8; i++) expect_ev(8'h15 + 8'(i), 0, 0);
    @(negedge clk);
    chk("ovf_set", {9'd0, overflow}, 10'd1);
    chk("full_head", {ev_valid, ev_code, ev_ext}, {1'b1, 8'h15, 1'b0});
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", {9'd0, overflow}, 10'd0);
    chk("head_stable", {ev_code, ev_ext, ev_break}, {8'h15, 2'b00});
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    send(8'h1E);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", {9'd0, overflow}, 10'd1);
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    ev_ready = 1'b1;
    send(8'h1F);
    expect_ev(8'h1F, 0, 0);
    @(negedge clk);
    chk("full_push_pop_no_ovf", {9'd0, overflow}, 10'd0);
    @(posedge clk);
    #1;
    drain();

    // prefix timeout: one cycle short keeps the break, full count abandons it
    do_reset();
    expect_ev(8'h1C, 0, 1);
    send(8'hF0);
    repeat (TO - 1) @(posedge clk);
    #1;
    send(8'h1C);
    drain();
    expect_ev(8'h1C, 0, 0);
    send(8'hF0);
    repeat (TO) @(posedge clk);
    #1;
    send(8'h1C);
    drain();

    // reset mid-sequence drops the E0 prefix
    send(8'hE0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_ev(8'h75, 0, 0);
    send(8'h75);
    drain();

    // typematic repeats
    do_reset();
    expect_ev(8'h1C, 0, 0);
`ifndef PS2DEC_TYPEMATIC_FILTER_EN
    expect_ev(8'h1C, 0, 0);
    expect_ev(8'h1C, 0, 0);
`endif
    expect_ev(8'h1C, 0, 1);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain();

    chk("queue_empty", 10'(exp_q.size()), 10'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
